// File: rtl/radix2_bfly_pipe.sv
// Radix-2 DIT butterfly: o1 = A + W*B, o2 = A - W*B, three register stages with
// a single stall-all handshake, optional divide-by-2 and sticky saturation flag.
module radix2_bfly_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int TW_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [BIT_WIDTH-1:0] re_i1,
  input  logic signed [BIT_WIDTH-1:0] im_i1,
  input  logic signed [BIT_WIDTH-1:0] re_i2,
  input  logic signed [BIT_WIDTH-1:0] im_i2,
  input  logic signed [TW_WIDTH-1:0]  cos_data,
  input  logic signed [TW_WIDTH-1:0]  sin_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        scale,
  output logic signed [BIT_WIDTH-1:0] re_o1,
  output logic signed [BIT_WIDTH-1:0] im_o1,
  output logic signed [BIT_WIDTH-1:0] re_o2,
  output logic signed [BIT_WIDTH-1:0] im_o2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int PW = BIT_WIDTH + TW_WIDTH + 1;
  // One guard bit beyond BIT_WIDTH+2 so a twiddle near -2.0 cannot wrap the sum.
  localparam int SW = BIT_WIDTH + 3;
  localparam int SH = TW_WIDTH - 2;
  localparam logic signed [PW:0]   RND  = (PW+1)'(2 ** (SH - 1));
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (BIT_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (BIT_WIDTH - 1)));

  function automatic logic signed [SW-1:0] round_prod(input logic signed [PW-1:0] p);
    logic signed [PW:0] t;
    t = (PW+1)'(p) + RND;
    return SW'(t >>> SH);
  endfunction

  function automatic logic signed [SW-1:0] scale_sum(input logic signed [SW-1:0] s,
                                                     input logic sc);
    return sc ? (s >>> 1) : s;
  endfunction

  function automatic logic is_sat(input logic signed [SW-1:0] s);
    return (s > SMAX) || (s < SMIN);
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] sat(input logic signed [SW-1:0] s);
    if (s > SMAX) return BIT_WIDTH'(SMAX);
    if (s < SMIN) return BIT_WIDTH'(SMIN);
    return BIT_WIDTH'(s);
  endfunction

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  logic signed [BIT_WIDTH-1:0] a_re_p0_q, a_im_p0_q, b_re_p0_q, b_im_p0_q;
  logic signed [TW_WIDTH-1:0]  cos_p0_q, sin_p0_q;
  logic                        scale_p0_q, vld_p0_q;

  logic signed [BIT_WIDTH-1:0] a_re_p1_q, a_im_p1_q;
  logic signed [PW-1:0]        pr_p1_q, pi_p1_q, pr_p1_d, pi_p1_d;
  logic                        scale_p1_q, vld_p1_q;

  logic signed [BIT_WIDTH-1:0] re1_p2_q, im1_p2_q, re2_p2_q, im2_p2_q;
  logic signed [BIT_WIDTH-1:0] re1_p2_d, im1_p2_d, re2_p2_d, im2_p2_d;
  logic                        vld_p2_q, ovf_q, ovf_d, any_sat;

  // ---- S1 -> S2: full-precision complex product W*B
  always_comb begin
    pr_p1_d = PW'(b_re_p0_q) * PW'(cos_p0_q) - PW'(b_im_p0_q) * PW'(sin_p0_q);
    pi_p1_d = PW'(b_im_p0_q) * PW'(cos_p0_q) + PW'(b_re_p0_q) * PW'(sin_p0_q);
  end

  // ---- S2 -> S3: round, add/subtract, scale, saturate
  always_comb begin
    logic signed [SW-1:0] rnd_re, rnd_im, s_re1, s_im1, s_re2, s_im2;
    rnd_re   = round_prod(pr_p1_q);
    rnd_im   = round_prod(pi_p1_q);
    s_re1    = scale_sum(SW'(a_re_p1_q) + rnd_re, scale_p1_q);
    s_im1    = scale_sum(SW'(a_im_p1_q) + rnd_im, scale_p1_q);
    s_re2    = scale_sum(SW'(a_re_p1_q) - rnd_re, scale_p1_q);
    s_im2    = scale_sum(SW'(a_im_p1_q) - rnd_im, scale_p1_q);
    re1_p2_d = sat(s_re1);
    im1_p2_d = sat(s_im1);
    re2_p2_d = sat(s_re2);
    im2_p2_d = sat(s_im2);
    any_sat  = is_sat(s_re1) | is_sat(s_im1) | is_sat(s_re2) | is_sat(s_im2);
    ovf_d    = ovf_q;
    if (ovf_clr)                      ovf_d = 1'b0;
    if (adv && vld_p1_q && any_sat)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_re_p0_q  <= re_i1;
      a_im_p0_q  <= im_i1;
      b_re_p0_q  <= re_i2;
      b_im_p0_q  <= im_i2;
      cos_p0_q   <= cos_data;
      sin_p0_q   <= sin_data;
      scale_p0_q <= scale;
      a_re_p1_q  <= a_re_p0_q;
      a_im_p1_q  <= a_im_p0_q;
      pr_p1_q    <= pr_p1_d;
      pi_p1_q    <= pi_p1_d;
      scale_p1_q <= scale_p0_q;
    end
  end

  // Output data is reset too so the ports read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      ovf_q    <= 1'b0;
      re1_p2_q <= '0;
      im1_p2_q <= '0;
      re2_p2_q <= '0;
      im2_p2_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (adv) begin
        vld_p0_q <= in_valid;
        vld_p1_q <= vld_p0_q;
        vld_p2_q <= vld_p1_q;
        re1_p2_q <= re1_p2_d;
        im1_p2_q <= im1_p2_d;
        re2_p2_q <= re2_p2_d;
        im2_p2_q <= im2_p2_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign ovf       = ovf_q;
  assign re_o1     = re1_p2_q;
  assign im_o1     = im1_p2_q;
  assign re_o2     = re2_p2_q;
  assign im_o2     = im2_p2_q;

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Directed-vector bench for radix2_bfly_pipe (BIT_WIDTH=16, TW_WIDTH=8, 1.0 = 64).
module tb_radix2_bfly_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [15:0] re_i1, im_i1, re_i2, im_i2;
  logic signed [7:0]  cos_data, sin_data;
  logic in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] re_o1, im_o1, re_o2, im_o2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  radix2_bfly_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .re_i1(re_i1), .im_i1(im_i1), .re_i2(re_i2), .im_i2(im_i2),
    .cos_data(cos_data), .sin_data(sin_data),
    .in_valid(in_valid), .in_ready(in_ready), .scale(scale),
    .re_o1(re_o1), .im_o1(im_o1), .re_o2(re_o2), .im_o2(im_o2),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    int are, aim, bre, bim, c, s;
    bit sc;
    int o1re, o1im, o2re, o2im;
    bit ov;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    re_i1 = 16'(v.are); im_i1 = 16'(v.aim);
    re_i2 = 16'(v.bre); im_i2 = 16'(v.bim);
    cos_data = 8'(v.c); sin_data = 8'(v.s);
    scale = v.sc;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 12) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_re_o1"}, re_o1, v.o1re);
    chk({nm, "_im_o1"}, im_o1, v.o1im);
    chk({nm, "_re_o2"}, re_o2, v.o2re);
    chk({nm, "_im_o2"}, im_o2, v.o2im);
    chk({nm, "_ovf"}, ovf, int'(v.ov));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, oidx, pulses;
    bit stalled;
    int h[4];
    vec_t rv;

    //          A re,   A im,   B re,  B im,  cos, sin, sc,  o1re,  o1im,  o2re,   o2im, ovf
    vecs[0]  = '{100,    50,     20,    -10,   64,  0,   0,   120,    40,    80,     60,    0};
    vecs[1]  = '{100,    50,     20,    -10,   0,   -64, 0,   90,     30,    110,    70,    0};
    vecs[2]  = '{32000,  0,      32000, 0,     64,  0,   0,   32767,  0,     0,      0,     1};
    vecs[3]  = '{32000,  0,      32000, 0,     64,  0,   1,   32000,  0,     0,      0,     0};
    vecs[4]  = '{-32000, 0,      -32000,0,     64,  0,   0,   -32768, 0,     0,      0,     1};
    vecs[5]  = '{0,      0,      1,     0,     32,  0,   0,   1,      0,     -1,     0,     0};
    vecs[6]  = '{0,      0,      -1,    0,     32,  0,   0,   0,      0,     0,      0,     0};
    vecs[7]  = '{3,      -3,     0,     0,     64,  0,   1,   1,      -2,    1,      -2,    0};
    vecs[8]  = '{10,     20,     5,     7,     -64, 0,   0,   5,      13,    15,     27,    0};
    vecs[9]  = '{0,      0,      3,     4,     0,   64,  0,   -4,     3,     4,      -3,    0};
    vecs[10] = '{0,      -30000, 0,     30000, 64,  0,   0,   0,      0,     0,      -32768,1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_re_o1", re_o1, 0);
    chk("rst_im_o2", im_o2, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Saturation coinciding with ovf_clr: the set must win, then stay sticky.
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    drive(vecs[2]); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins_valid", out_valid, 1);
    chk("ovf_set_wins", ovf, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);

    // Stream of 8 with downstream stall on cycles 4-5.
    cos_data = 8'sd64; sin_data = 8'sd0; scale = 1'b0;
    idx = 0; oidx = 0; stalled = 1'b0;
    for (int c = 0; c < 40 && oidx < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c == 4 || c == 5);
      in_valid  = (idx < 8);
      re_i1 = 16'((idx + 1) * 100);
      im_i1 = 16'(-(idx + 1) * 10);
      re_i2 = 16'(idx + 1);
      im_i2 = 16'(2 * (idx + 1));
      @(negedge clk);
      if (c == 4 || c == 5) chk($sformatf("stall_in_ready_c%0d", c), in_ready, 0);
      if (stalled) begin
        chk("hold_re_o1", re_o1, h[0]);
        chk("hold_im_o1", im_o1, h[1]);
        chk("hold_re_o2", re_o2, h[2]);
        chk("hold_im_o2", im_o2, h[3]);
      end
      stalled = out_valid && !out_ready;
      h[0] = re_o1; h[1] = im_o1; h[2] = re_o2; h[3] = im_o2;
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d_re_o1", oidx), re_o1, 101 * (oidx + 1));
        chk($sformatf("stream%0d_im_o1", oidx), im_o1, -8 * (oidx + 1));
        chk($sformatf("stream%0d_re_o2", oidx), re_o2, 99 * (oidx + 1));
        chk($sformatf("stream%0d_im_o2", oidx), im_o2, -12 * (oidx + 1));
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("stream_count", oidx, 8);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);

    // Reset with three transfers in flight.
    #1;
    for (int k = 0; k < 3; k++) begin
      re_i1 = 16'(500 + k); im_i1 = 16'(k); re_i2 = 16'(k + 1); im_i2 = 16'(0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_re_o1", re_o1, 0);
    chk("async_rst_im_o1", im_o1, 0);
    chk("async_rst_re_o2", re_o2, 0);
    chk("async_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rv = '{7, -7, 1, 1, 64, 0, 0, 8, -6, 6, -8, 0};
    run_vec(rv, "post_reset");
    pulses = 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("post_reset_pulses", pulses, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
